q_pulse_serializer: RTL
=======================

Name: q_pulse_serializer

Overview:
- Synthesizable transmitter for the q_serialized pulse-train interface.
- Converts a parallel charge value into a train of fixed-width pulses, each worth Q_PER_PULSE units, followed by an idle gap that the Q-measurement receiver's watchdog treats as end-of-frame.
- Used as the on-chip loopback/BIST source in place of the behavioural resonant-system emulation, and as the driver of that interface in silicon test modes.

Parameters:
- BUS_WIDTH, 10, width of q_value and pulse_cnt.
- Q_PER_PULSE, 3, charge units represented by one pulse (>=1).
- PULSE_DURATION, 3, clock cycles q_serialized is high per pulse (>=1).
- GAP_DURATION, 2, low cycles between consecutive pulses of one frame (>=1).
- FRAME_GAP, 8, low cycles after the last pulse before the frame closes; must be >= 2**WTD_BUS_WIDTH of the receiver (8 for WTD_BUS_WIDTH=3).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  transmit enable; low aborts any frame in progress.
- q_valid  input  1  q_value is valid.
- q_value  input  BUS_WIDTH  charge value to serialize.
- q_ready  output  1  block can accept a value; combinational = (state==IDLE) & start.
- q_serialized  output  1  registered pulse-train output.
- busy  output  1  registered; high in any state other than IDLE.
- frame_done  output  1  registered; one-cycle strobe when a frame completes.
- pulse_cnt  output  BUS_WIDTH  registered; pulses emitted in the current or last frame.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, q_serialized=0, busy=0, frame_done=0, pulse_cnt=0, internal remaining/timer=0. q_ready then follows start.
- Accept: on a rising edge with q_valid & q_ready.
  - remaining <= q_value; pulse_cnt <= 0.
  - If q_value==0: go to FRAME_GAP. Otherwise go to PULSE_HI.
  - q_valid while not ready is ignored; no buffering.
- States:
  - IDLE: q_serialized=0.
  - PULSE_HI: q_serialized=1 for exactly PULSE_DURATION cycles. On the last cycle, pulse_cnt increments.
    - If remaining <= Q_PER_PULSE: remaining <= 0, next state FRAME_GAP.
    - Else: remaining <= remaining - Q_PER_PULSE, next state PULSE_LO.
  - PULSE_LO: q_serialized=0 for GAP_DURATION cycles, then PULSE_HI.
  - FRAME_GAP: q_serialized=0 for FRAME_GAP cycles, then IDLE. frame_done=1 during the first IDLE cycle only.
- Pulse count is ceil(q_value/Q_PER_PULSE), computed by iterative subtraction. No divider.
- Timing, with acceptance at edge k:
  - Pulse i is high in cycles k+1+i*(PULSE_DURATION+GAP_DURATION) through +PULSE_DURATION-1.
  - Frame length is N*PULSE_DURATION + (N-1)*GAP_DURATION + FRAME_GAP cycles; frame_done follows on the next cycle.
- start deasserted mid-frame:
  - Next edge: state=IDLE, q_serialized=0.
  - No frame_done; pulse_cnt holds the partial count.
- start reasserted together with q_valid in IDLE: accepted on the same edge.
- frame_done and acceptance may coincide (q_ready is high in that IDLE cycle), giving back-to-back frames.
- The timer is a single down-counter sized for max(PULSE_DURATION, GAP_DURATION, FRAME_GAP).
- remaining never underflows; values up to 2**BUS_WIDTH-1 are supported.

Test Plan:
- Reset then start=1, q_value=10, one-cycle q_valid at edge k -> 4 pulses, high at k+1..3, k+6..8, k+11..13, k+16..18. Then low k+19..26, frame_done=1 at k+27, pulse_cnt=4, busy low at k+27.
- q_value=9 -> exactly 3 pulses, pulse_cnt=3 (exact multiple, no extra pulse). q_value=1 -> 1 pulse, pulse_cnt=1.
- q_value=0 -> q_serialized stays 0, frame_done at k+9, pulse_cnt=0.
- q_value=1023 -> 341 pulses, frame_done at k+1+341*5-2+8. Receiver loopback reports 1023±(Q_PER_PULSE-1).
- start dropped during pulse 2 of q_value=30 -> q_serialized=0 on next edge, state IDLE, no frame_done, pulse_cnt=1.
- rst asserted asynchronously mid-PULSE_HI -> q_serialized, busy, pulse_cnt go to 0 immediately without a clock edge. After release, a new frame is accepted. q_valid held high across frame_done -> second frame starts at the frame_done edge.

Source files
------------

// File: rtl/q_pulse_serializer_if.sv
// rtl/q_pulse_serializer_if.sv - parallel charge-in / pulse-train-out bundle
// master drives the value handshake; slave is the serializer.
interface q_pulse_serializer_if #(
  parameter int BUS_WIDTH = 10
);
  logic                 start;
  logic                 q_valid;
  logic [BUS_WIDTH-1:0] q_value;
  logic                 q_ready;
  logic                 q_serialized;
  logic                 busy;
  logic                 frame_done;
  logic [BUS_WIDTH-1:0] pulse_cnt;

  modport master (
    output start, q_valid, q_value,
    input  q_ready, q_serialized, busy, frame_done, pulse_cnt
  );

  modport slave (
    input  start, q_valid, q_value,
    output q_ready, q_serialized, busy, frame_done, pulse_cnt
  );
endinterface

// File: rtl/q_pulse_serializer.sv
// rtl/q_pulse_serializer.sv - charge value to fixed-width pulse train serializer
// Emits ceil(q_value/Q_PER_PULSE) pulses, then a FRAME_GAP idle gap closing the frame.
module q_pulse_serializer #(
  parameter int BUS_WIDTH      = 10,
  parameter int Q_PER_PULSE    = 3,
  parameter int PULSE_DURATION = 3,
  parameter int GAP_DURATION   = 2,
  parameter int FRAME_GAP      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  q_pulse_serializer_if.slave     bus
);
  localparam int TMAX_A = (PULSE_DURATION > GAP_DURATION) ? PULSE_DURATION : GAP_DURATION;
  localparam int TMAX   = (TMAX_A > FRAME_GAP) ? TMAX_A : FRAME_GAP;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0]        T_PULSE = TW'(PULSE_DURATION - 1);
  localparam logic [TW-1:0]        T_GAP   = TW'(GAP_DURATION - 1);
  localparam logic [TW-1:0]        T_FRAME = TW'(FRAME_GAP - 1);
  localparam logic [BUS_WIDTH-1:0] QPP     = BUS_WIDTH'(Q_PER_PULSE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HI    = 2'd1;
  localparam logic [1:0] S_LO    = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]           state;
  logic [TW-1:0]        timer;
  logic [BUS_WIDTH-1:0] remaining;
  logic                 ser_r;
  logic                 busy_r;
  logic                 done_r;
  logic [BUS_WIDTH-1:0] cnt_r;
  logic                 accept;

  assign bus.q_ready      = (state == S_IDLE) & bus.start;
  assign accept           = bus.q_ready & bus.q_valid;
  assign bus.q_serialized = ser_r;
  assign bus.busy         = busy_r;
  assign bus.frame_done   = done_r;
  assign bus.pulse_cnt    = cnt_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      remaining <= '0;
      ser_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cnt_r     <= '0;
    end else begin
      done_r <= 1'b0;
      // Dropping start abandons the frame silently; the partial count stays visible.
      if ((state != S_IDLE) && !bus.start) begin
        state  <= S_IDLE;
        timer  <= '0;
        ser_r  <= 1'b0;
        busy_r <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              remaining <= bus.q_value;
              cnt_r     <= '0;
              busy_r    <= 1'b1;
              if (bus.q_value == '0) begin
                state <= S_GAP;
                timer <= T_FRAME;
              end else begin
                state <= S_HI;
                ser_r <= 1'b1;
                timer <= T_PULSE;
              end
            end
          end
          S_HI: begin
            if (timer == '0) begin
              cnt_r <= cnt_r + BUS_WIDTH'(1);
              ser_r <= 1'b0;
              if (remaining <= QPP) begin
                remaining <= '0;
                state     <= S_GAP;
                timer     <= T_FRAME;
              end else begin
                remaining <= remaining - QPP;
                state     <= S_LO;
                timer     <= T_GAP;
              end
            end else begin
              timer <= timer - TW'(1);
            end
          end
          S_LO: begin
            if (timer == '0) begin
              state <= S_HI;
              ser_r <= 1'b1;
              timer <= T_PULSE;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          S_GAP: begin
            if (timer == '0) begin
              state  <= S_IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          default: begin
            state <= S_IDLE;
            ser_r <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
